lane_grant_scheduler32: RTL and testbench

Sequencing controller for the 32-lane valid path. It captures a 32-requester × 32-lane request matrix, reduces it to a 32-bit pending-lane mask, and issues one lane grant per cycle. Each grant names one lane and one requester. Lanes are walked in ascending order, and a requester is chosen per lane by rotating priority. It sits between the requester request matrix and the lane datapath, and is handshaked by the downstream lane consumer.

---
 rtl/lane_grant_scheduler32_if.sv | 28 ++
 rtl/lane_grant_scheduler32.sv | 130 +++++++++++++
 tb/tb_lane_grant_scheduler32.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/lane_grant_scheduler32_if.sv
// Handshake and request bundle for lane_grant_scheduler32.
// The slave modport is the scheduler side; master is the requester/consumer side.
interface lane_grant_scheduler32_if;
  localparam int unsigned N_REQ  = 32;
  localparam int unsigned N_LANE = 32;
  localparam int unsigned IDX_W  = 5;

  logic                      start;
  logic                      abort;
  logic [N_REQ*N_LANE-1:0]   req_mat;
  logic                      gnt_ready;
  logic                      gnt_valid;
  logic [IDX_W-1:0]          gnt_lane;
  logic [IDX_W-1:0]          gnt_req;
  logic [N_LANE-1:0]         lane_pend;
  logic                      busy;
  logic                      done;

  modport master (
    output start, abort, req_mat, gnt_ready,
    input  gnt_valid, gnt_lane, gnt_req, lane_pend, busy, done
  );

  modport slave (
    input  start, abort, req_mat, gnt_ready,
    output gnt_valid, gnt_lane, gnt_req, lane_pend, busy, done
  );
endinterface

// File: rtl/lane_grant_scheduler32.sv
// Walks pending lanes in ascending order and grants one (lane, requester) pair per cycle.
// Define LGS_RR_PRIORITY_EN for rotating requester priority; otherwise lowest requester wins.
module lane_grant_scheduler32 (
  input  logic                     clk,
  input  logic                     rst_n,
  lane_grant_scheduler32_if.slave  bus
);
  localparam int unsigned N_REQ  = 32;
  localparam int unsigned N_LANE = 32;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t                   state, state_n;
  logic [N_REQ*N_LANE-1:0]  mat_q, mat_n;
  logic [N_LANE-1:0]        req_or, pend_cur, pend_n;
  logic [N_REQ-1:0]         col, col_rot;
  logic [2*N_REQ-1:0]       col_dbl;
  logic [IDX_W-1:0]         ptr_sel, sel_lane, sel_req, lane_n, req_n;
  logic                     valid_n, busy_n, done_n, accept;

  function automatic logic [IDX_W-1:0] lowest(input logic [N_REQ-1:0] v);
    lowest = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX_W'(i);
    end
  endfunction

  assign accept = bus.gnt_valid & bus.gnt_ready;

`ifdef LGS_RR_PRIORITY_EN
  logic [IDX_W-1:0] ptr;

  // Pointer used for this cycle's selection already reflects a coinciding accept.
  assign ptr_sel = accept ? IDX_W'(bus.gnt_req + IDX_W'(1)) : ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr_sel;
  end
`else
  assign ptr_sel = '0;
`endif

  // Pending-lane mask at capture time: OR of all requester slices.
  always_comb begin
    req_or = '0;
    for (int k = 0; k < N_REQ; k++) req_or = req_or | bus.req_mat[k*N_LANE +: N_LANE];
  end

  // Next grant candidate: lowest pending lane, then first requester at or after ptr.
  always_comb begin
    pend_cur = bus.lane_pend;
    if (accept) pend_cur[bus.gnt_lane] = 1'b0;
    sel_lane = lowest(pend_cur);
    col = '0;
    for (int k = 0; k < N_REQ; k++) col[k] = mat_q[k*N_LANE + int'(sel_lane)];
    col_dbl = {col, col};
    col_rot = N_REQ'(col_dbl >> ptr_sel);
    sel_req = IDX_W'(ptr_sel + lowest(col_rot));
  end

  always_comb begin
    state_n = state;
    mat_n   = mat_q;
    pend_n  = bus.lane_pend;
    valid_n = bus.gnt_valid;
    lane_n  = bus.gnt_lane;
    req_n   = bus.gnt_req;
    busy_n  = bus.busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mat_n   = bus.req_mat;
          pend_n  = req_or;
          busy_n  = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.abort) begin
          state_n = IDLE;
          pend_n  = '0;
          valid_n = 1'b0;
          lane_n  = '0;
          req_n   = '0;
          busy_n  = 1'b0;
        end else if (!bus.gnt_valid || accept) begin
          pend_n = pend_cur;
          if (pend_cur == '0) begin
            state_n = IDLE;
            valid_n = 1'b0;
            lane_n  = '0;
            req_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            valid_n = 1'b1;
            lane_n  = sel_lane;
            req_n   = sel_req;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mat_q         <= '0;
      bus.lane_pend <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_lane  <= '0;
      bus.gnt_req   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_n;
      mat_q         <= mat_n;
      bus.lane_pend <= pend_n;
      bus.gnt_valid <= valid_n;
      bus.gnt_lane  <= lane_n;
      bus.gnt_req   <= req_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
    end
  end
endmodule

// File: tb/tb_lane_grant_scheduler32.sv
// Directed bench for lane_grant_scheduler32; expectations follow LGS_RR_PRIORITY_EN if defined.
module tb_lane_grant_scheduler32;
`ifdef LGS_RR_PRIORITY_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  lane_grant_scheduler32_if bus ();

  lane_grant_scheduler32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),      32'd0);
    chk({tag, "_pend"},  bus.lane_pend,      32'd0);
    chk({tag, "_lane"},  32'(bus.gnt_lane),  32'd0);
    chk({tag, "_req"},   32'(bus.gnt_req),   32'd0);
  endtask

  task automatic chk_grant(input string tag, input int lane, input int req);
    chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'd1);
    chk({tag, "_lane"},  32'(bus.gnt_lane),  32'(lane));
    chk({tag, "_req"},   32'(bus.gnt_req),   32'(req));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.req_mat   = '0;
    bus.gnt_ready = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // All-ones pass, consumer always ready
    bus.req_mat   = '1;
    bus.gnt_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ones_busy", 32'(bus.busy), 32'd1);
    chk("ones_pend", bus.lane_pend, 32'hffff_ffff);
    chk("ones_novalid", 32'(bus.gnt_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_grant($sformatf("ones_g%0d", i), i, RR ? i : 0);
      chk($sformatf("ones_nodone%0d", i), 32'(bus.done), 32'd0);
    end
    tick();
    chk("ones_end_valid", 32'(bus.gnt_valid), 32'd0);
    chk("ones_end_busy",  32'(bus.busy),      32'd0);
    chk("ones_end_done",  32'(bus.done),      32'd1);
    chk("ones_end_pend",  bus.lane_pend,      32'd0);
    tick();
    chk("ones_done_drop", 32'(bus.done), 32'd0);

    // Backpressure: requesters 0 and 7 both want lanes 2 and 9
    bus.req_mat        = '0;
    bus.req_mat[0*32+2] = 1'b1;
    bus.req_mat[0*32+9] = 1'b1;
    bus.req_mat[7*32+2] = 1'b1;
    bus.req_mat[7*32+9] = 1'b1;
    bus.gnt_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("bp_pend0", bus.lane_pend, 32'h0000_0204);
    tick();
    chk_grant("bp_first", 2, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant($sformatf("bp_hold%0d", i), 2, 0);
    end
    bus.gnt_ready = 1'b1;
    tick();
    chk_grant("bp_second", 9, RR ? 7 : 0);
    chk("bp_pend1", bus.lane_pend, 32'h0000_0200);
    tick();
    chk("bp_done", 32'(bus.done), 32'd1);
    chk("bp_end_valid", 32'(bus.gnt_valid), 32'd0);
    tick();

    // Empty matrix
    bus.req_mat = '0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("empty_busy", 32'(bus.busy), 32'd1);
    chk("empty_novalid0", 32'(bus.gnt_valid), 32'd0);
    chk("empty_nodone", 32'(bus.done), 32'd0);
    tick();
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_busy_drop", 32'(bus.busy), 32'd0);
    chk("empty_novalid1", 32'(bus.gnt_valid), 32'd0);
    tick();
    chk("empty_done_drop", 32'(bus.done), 32'd0);

    // Single request: requester 3, lane 5
    bus.req_mat          = '0;
    bus.req_mat[32*3+5]  = 1'b1;
    bus.start            = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.req_mat = '0;
    chk("single_pend", bus.lane_pend, 32'h0000_0020);
    chk("single_novalid", 32'(bus.gnt_valid), 32'd0);
    tick();
    chk_grant("single_g", 5, 3);
    tick();
    chk("single_done", 32'(bus.done), 32'd1);
    chk("single_valid_drop", 32'(bus.gnt_valid), 32'd0);
    chk("single_pend_end", bus.lane_pend, 32'd0);
    tick();
    chk("single_done_drop", 32'(bus.done), 32'd0);

    // All-ones pass, second start while busy, abort together with the 2nd accept
    bus.req_mat = '1;
    bus.start   = 1'b1;
    tick();
    bus.req_mat = '0;
    tick();
    chk_grant("ab_g0", 0, RR ? 4 : 0);
    bus.start = 1'b0;
    tick();
    chk_grant("ab_g1", 1, RR ? 5 : 0);
    chk("ab_pend", bus.lane_pend, 32'hffff_fffe);
    chk("ab_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("ab_after");
    chk("ab_nodone0", 32'(bus.done), 32'd0);
    tick();
    chk("ab_nodone1", 32'(bus.done), 32'd0);
    // Fresh pass: lane 4 requested by 5 and 7; ptr must reflect the accept at the abort edge
    bus.req_mat          = '0;
    bus.req_mat[5*32+4]  = 1'b1;
    bus.req_mat[7*32+4]  = 1'b1;
    bus.start            = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("fresh_pend", bus.lane_pend, 32'h0000_0010);
    tick();
    chk_grant("fresh_g", 4, RR ? 7 : 5);
    tick();
    chk("fresh_done", 32'(bus.done), 32'd1);
    tick();

    // Asynchronous reset in the middle of an all-ones pass
    bus.req_mat = '1;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk_grant("rst_pre_g0", 0, RR ? 8 : 0);
    tick();
    chk_grant("rst_pre_g1", 1, RR ? 9 : 0);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    chk("rst_async_done", 32'(bus.done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_idle("rst_held");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rst_post_pend", bus.lane_pend, 32'hffff_ffff);
    tick();
    chk_grant("rst_post_g0", 0, 0);
    tick();
    chk_grant("rst_post_g1", 1, RR ? 1 : 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("final_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
